// File: rtl/div_pkg.sv
// Shared definitions for the signed divider: FSM state encoding.
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the
// divisor magnitude, keep the difference if non-negative, otherwise restore.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // Shift/subtract/restore; the extra top bit of w_diff is the borrow.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {2'b00, i_dvs};
        o_qbit  = ~w_diff[WIDTH+1];
        o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed restoring divider, truncating toward zero.
// Fixed latency: start edge to done = WIDTH+1 cycles; divide-by-zero flagged.
module signed_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd_mag;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo_mag;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_qbit;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) read as unsigned.
    always_comb begin
        w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
        w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd_mag[WIDTH-1]),
        .i_dvs  (r_dvs_mag),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    // Sign correction; a zero divisor leaves the remainder equal to the dividend.
    always_comb begin
        w_quo_fix = r_dz ? '1 : (r_q_neg ? -r_quo_mag : r_quo_mag);
        w_rem_fix = r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = CALC;
            CALC:    if (r_cnt == CNT_LAST) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy        = (r_state == CALC) || (r_state == FIX);
        done        = r_done;
        quotient    = r_quotient;
        remainder   = r_remainder;
        div_by_zero = r_div_by_zero;
    end

    // Datapath: operand capture, iteration, and result registration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_dvd_mag     <= '0;
            r_dvs_mag     <= '0;
            r_rem         <= '0;
            r_quo_mag     <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dz          <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd_mag <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_r_neg   <= dividend[WIDTH-1];
                        r_dz      <= (divisor == '0);
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo_mag <= '0;
                    end
                end
                CALC: begin
                    r_rem     <= w_step_rem;
                    r_quo_mag <= {r_quo_mag[WIDTH-2:0], w_step_qbit};
                    r_dvd_mag <= {r_dvd_mag[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt + CNT_ONE;
                end
                FIX: begin
                    r_quotient    <= w_quo_fix;
                    r_remainder   <= w_rem_fix;
                    r_div_by_zero <= r_dz;
                    r_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (two's complement); all concrete values below assume WIDTH=8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  signed numerator; sampled with start.
REQ-006 SHALL have port divisor  input  WIDTH  signed denominator; sampled with start.
REQ-007 SHALL have port busy  output  1  high while a division is in flight (CALC or FIX).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid from this cycle.
REQ-009 SHALL have port quotient  output  WIDTH  signed result, held until next done.
REQ-010 SHALL have port remainder  output  WIDTH  signed result, held until next done.
REQ-011 SHALL have port div_by_zero  output  1  set with done when divisor was 0; held until next done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX; IDLE->CALC on start; CALC->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-013 SHALL, on the edge E0 sampling start=1 in IDLE, register operand magnitudes, result signs (q sign = sign(dividend) XOR sign(divisor), r sign = sign(dividend)), a zero-divisor flag, and clear the iteration counter.
REQ-014 SHALL perform one restoring-division step per CALC edge (shift partial remainder left with next dividend magnitude bit, trial-subtract divisor magnitude, keep if non-negative and set quotient bit, else restore), MSB first; WIDTH steps on edges E1..E8.
REQ-015 SHALL hold the partial remainder in WIDTH+1 bits so that magnitude 2^(WIDTH-1) (e.g. -128) is exact.
REQ-016 SHALL, at edge E9 (FIX), register sign-corrected quotient and remainder, assert done for exactly the following cycle, and deassert busy; latency start-edge to done = 9 cycles, fixed for all operands.
REQ-017 SHALL truncate toward zero: dividend = quotient*divisor + remainder, |remainder| < |divisor|, remainder sign equals dividend sign or remainder is 0.
REQ-018 SHALL, for divisor 0, keep the same latency and produce quotient all-ones, remainder = dividend, div_by_zero=1.
REQ-019 SHALL, for most-negative / -1, produce quotient = most-negative (wrap, 8'h80), remainder 0, div_by_zero=0.
REQ-020 SHALL ignore start while busy; inputs may change freely during CALC/FIX without effect.
REQ-021 SHALL accept start in the cycle done is high (state already IDLE), giving back-to-back throughput of one result per 10 cycles.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, enter IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, including mid-CALC/FIX (in-flight result discarded, no done pulse).
REQ-023 SHALL take precedence of rst_n over start on the same edge.

Structure
REQ-024 SHALL place the state encoding localparams (IDLE, CALC, FIX) in shared package div_pkg.
REQ-025 SHALL factor the per-iteration shift/trial-subtract/restore as combinational sub-module div_step (inputs: partial remainder, next bit, divisor magnitude; outputs: new remainder, quotient bit).
REQ-026 SHALL size the iteration counter as the minimal width able to count WIDTH.

Verification
REQ-027 SHALL cover 100 / 7 -> done 9 cycles after start, quotient 14 (8'h0E), remainder 2, div_by_zero 0.
REQ-028 SHALL cover -100 / 7 -> quotient -14 (8'hF2), remainder -2 (8'hFE); 100 / -7 -> quotient 8'hF2, remainder 2.
REQ-029 SHALL cover -128 / -1 -> quotient 8'h80, remainder 0, div_by_zero 0; -128 / 1 -> quotient 8'h80, remainder 0.
REQ-030 SHALL cover 5 / 0 -> quotient 8'hFF, remainder 5, div_by_zero 1, same 9-cycle latency.
REQ-031 SHALL cover start pulsed again 3 cycles after 100/7 with 50/5 -> ignored, single done with quotient 14; then start during done cycle with 50/5 -> next done 10 cycles later with quotient 10, remainder 0.
REQ-032 SHALL cover rst_n=0 for one edge at E4 of a division -> no done pulse, all outputs 0, busy 0; subsequent 9 / 3 -> quotient 3, remainder 0.
